// File: rtl/osd_cmd_tx.sv
// Serialises OSD commands onto a strobed 16-bit word bus framed by io_osd.
// Block writes stream 256 bytes from an external buffer with one-cycle read latency.
module osd_cmd_tx #(
   parameter int STB_W = 1,
   parameter int GAP   = 2
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic        cmd_info,
   input  logic [4:0]  cmd_row,
   input  logic [11:0] infox,
   input  logic [11:0] infoy,
   input  logic [5:0]  infow,
   input  logic [5:0]  infoh,
   input  logic [1:0]  rot,
   output logic [7:0]  rd_addr,
   input  logic [7:0]  rd_data,
   output logic        io_osd,
   output logic        io_strobe,
   output logic [15:0] io_din,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, FETCH, CLOSE} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic [2:0]  sel, sel_nx;
   logic        in_data, in_data_nx;
   logic [15:0] din_q, din_nx;
   logic [7:0]  addr_nx;
   logic        started;
   logic        accept;
   logic [15:0] cmd_word;
   logic [15:0] info_word;
   logic [2:0]  sel_inc;

   logic [1:0]  op_q;
   logic        info_q;
   logic [11:0] x_q, y_q;
   logic [5:0]  w_q, h_q;
   logic [1:0]  rot_q;

   assign accept  = cmd_valid && cmd_ready;
   assign sel_inc = sel + 3'd1;

   always_comb begin
      cmd_word = 16'h0000;
      case (cmd_op)
         2'd0:    cmd_word = 16'h0040;
         2'd1:    cmd_word = 16'h0041 | {13'h0, cmd_info, 2'b00};
         2'd2:    cmd_word = 16'h0020 | {11'h0, cmd_row};
         default: cmd_word = 16'h0000;
      endcase
   end

   // Info words follow the command word in the order x, y, w, h, rot (sel 1..5).
   always_comb begin
      info_word = 16'h0000;
      case (sel_inc)
         3'd1:    info_word = {4'h0, x_q};
         3'd2:    info_word = {4'h0, y_q};
         3'd3:    info_word = {10'h0, w_q};
         3'd4:    info_word = {10'h0, h_q};
         default: info_word = {14'h0, rot_q};
      endcase
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      sel_nx     = sel;
      in_data_nx = in_data;
      din_nx     = din_q;
      addr_nx    = rd_addr;
      case (state)
         IDLE: begin
            if (accept && cmd_op != 2'd3) begin
               state_nx   = SETUP;
               din_nx     = cmd_word;
               sel_nx     = 3'd0;
               in_data_nx = 1'b0;
               cnt_nx     = 4'd0;
            end
         end
         SETUP: begin
            state_nx = STROBE;
            cnt_nx   = 4'd0;
            if (in_data) din_nx = {8'h00, rd_data};
         end
         STROBE: begin
            if (cnt == 4'(STB_W - 1)) begin
               cnt_nx   = 4'd0;
               state_nx = CLOSE;
               din_nx   = 16'h0000;
               if (in_data) begin
                  if (rd_addr != 8'hFF) begin
                     addr_nx  = rd_addr + 8'd1;
                     state_nx = FETCH;
                     din_nx   = din_q;
                  end
               end else if (sel == 3'd0) begin
                  if (op_q == 2'd1 && info_q) begin
                     sel_nx   = 3'd1;
                     din_nx   = info_word;
                     state_nx = SETUP;
                  end else if (op_q == 2'd2) begin
                     addr_nx    = 8'd0;
                     in_data_nx = 1'b1;
                     state_nx   = FETCH;
                     din_nx     = din_q;
                  end
               end else if (sel != 3'd5) begin
                  sel_nx   = sel_inc;
                  din_nx   = info_word;
                  state_nx = SETUP;
               end
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         FETCH: state_nx = SETUP;
         CLOSE: begin
            if (cnt == 4'(GAP - 1)) begin
               cnt_nx   = 4'd0;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Command fields are captured on acceptance so input changes never leak into a frame.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         sel     <= 3'd0;
         in_data <= 1'b0;
         din_q   <= 16'h0000;
         rd_addr <= 8'd0;
         started <= 1'b0;
         op_q    <= 2'd0;
         info_q  <= 1'b0;
         x_q     <= 12'd0;
         y_q     <= 12'd0;
         w_q     <= 6'd0;
         h_q     <= 6'd0;
         rot_q   <= 2'd0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         sel     <= sel_nx;
         in_data <= in_data_nx;
         din_q   <= din_nx;
         rd_addr <= addr_nx;
         started <= 1'b1;
         if (accept) begin
            op_q   <= cmd_op;
            info_q <= cmd_info;
            x_q    <= infox;
            y_q    <= infoy;
            w_q    <= infow;
            h_q    <= infoh;
            rot_q  <= rot;
         end
      end
   end

   // Data words show the buffer byte directly in SETUP since it arrives one cycle after rd_addr.
   assign io_din    = (state == SETUP && in_data) ? {8'h00, rd_data} : din_q;
   assign io_osd    = (state == SETUP) || (state == STROBE) || (state == FETCH);
   assign io_strobe = (state == STROBE);
   assign busy      = (state != IDLE);
   assign cmd_ready = (state == IDLE) && started;

endmodule

// File: tb/tb_osd_cmd_tx.sv
// Scoreboard bench for osd_cmd_tx: expected words queued at acceptance, compared on each strobe.
module tb_osd_cmd_tx;

   localparam int GAP = 2;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic        cmd_info = 1'b0;
   logic [4:0]  cmd_row = 5'd0;
   logic [11:0] infox = 12'd0, infoy = 12'd0;
   logic [5:0]  infow = 6'd0, infoh = 6'd0;
   logic [1:0]  rot = 2'd0;
   logic [7:0]  rd_addr;
   logic [7:0]  rd_data = 8'd0;
   logic        io_osd, io_strobe, busy;
   logic [15:0] io_din;

   logic        cmd_valid3 = 1'b0;
   logic        cmd_ready3, io_osd3, io_strobe3, busy3;
   logic [7:0]  rd_addr3;
   logic [7:0]  rd_data3 = 8'd0;
   logic [15:0] io_din3;

   logic [7:0]  mem [256];
   logic [15:0] expQ [$];
   int          checkCount = 0;
   int          errorCount = 0;
   int          busyTotal = 0, osdTotal = 0, lowRun = 0;
   logic        hadFrame = 1'b0, prevStrobe = 1'b0;

   osd_cmd_tx #(.STB_W(1), .GAP(GAP)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_info(cmd_info), .cmd_row(cmd_row), .infox(infox), .infoy(infoy),
      .infow(infow), .infoh(infoh), .rot(rot), .rd_addr(rd_addr), .rd_data(rd_data),
      .io_osd(io_osd), .io_strobe(io_strobe), .io_din(io_din), .busy(busy));

   osd_cmd_tx #(.STB_W(3), .GAP(3)) dut3 (
      .clk_sys(clk_sys), .reset_n(reset_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
      .cmd_op(cmd_op), .cmd_info(cmd_info), .cmd_row(cmd_row), .infox(infox), .infoy(infoy),
      .infow(infow), .infoh(infoh), .rot(rot), .rd_addr(rd_addr3), .rd_data(rd_data3),
      .io_osd(io_osd3), .io_strobe(io_strobe3), .io_din(io_din3), .busy(busy3));

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) rd_data <= mem[rd_addr];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pushExpected(input logic [1:0] op, input logic info, input logic [4:0] row,
                               input logic [11:0] x, input logic [11:0] y, input logic [5:0] w,
                               input logic [5:0] h, input logic [1:0] r);
      case (op)
         2'd0: expQ.push_back(16'h0040);
         2'd1: begin
            expQ.push_back(info ? 16'h0045 : 16'h0041);
            if (info) begin
               expQ.push_back({4'h0, x});
               expQ.push_back({4'h0, y});
               expQ.push_back({10'h0, w});
               expQ.push_back({10'h0, h});
               expQ.push_back({14'h0, r});
            end
         end
         2'd2: begin
            expQ.push_back({11'h001, row});
            for (int i = 0; i < 256; i++) expQ.push_back({8'h00, mem[i]});
         end
         default: ;
      endcase
   endtask

   // Monitor: scoreboard pushes on acceptance, pops on each strobe rise; frame gap tracking.
   always @(negedge clk_sys) begin
      if (!reset_n) begin
         hadFrame   <= 1'b0;
         prevStrobe <= 1'b0;
      end else begin
         if (cmd_valid && cmd_ready)
            pushExpected(cmd_op, cmd_info, cmd_row, infox, infoy, infow, infoh, rot);
         if (io_strobe && !prevStrobe) begin
            checkOutput("strobe_in_frame", {31'd0, io_osd}, 32'd1);
            if (expQ.size() == 0) checkOutput("unexpected_word", {16'd0, io_din}, 32'hFFFF_FFFF);
            else checkOutput("word", {16'd0, io_din}, {16'd0, expQ.pop_front()});
         end
         if (io_osd) begin
            if (!hadFrame || lowRun != 0) begin
               if (hadFrame) checkOutput("gap_min", {31'd0, lowRun >= GAP}, 32'd1);
            end
            hadFrame <= 1'b1;
            lowRun   <= 0;
         end else begin
            lowRun <= lowRun + 1;
         end
         prevStrobe <= io_strobe;
         if (busy) busyTotal <= busyTotal + 1;
         if (io_osd) osdTotal <= osdTotal + 1;
      end
   end

   task automatic waitReady(input string tag);
      int n = 0;
      while (!cmd_ready && n < 2000) begin
         @(posedge clk_sys); #1;
         n++;
      end
      if (!cmd_ready) checkOutput(tag, 32'd0, 32'd1);
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic info, input logic [4:0] row,
                                input logic [11:0] x, input logic [11:0] y, input logic [5:0] w,
                                input logic [5:0] h, input logic [1:0] r, input int expLat);
      int cyc, b0, o0;
      waitReady("ready_timeout");
      cmd_op = op; cmd_info = info; cmd_row = row;
      infox = x; infoy = y; infow = w; infoh = h; rot = r;
      cmd_valid = 1'b1;
      @(posedge clk_sys); #1;
      cmd_valid = 1'b0;
      b0 = busyTotal; o0 = osdTotal;
      cmd_op = 2'($urandom); cmd_info = 1'($urandom); cmd_row = 5'($urandom);
      infox = 12'($urandom); infoy = 12'($urandom); infow = 6'($urandom);
      infoh = 6'($urandom); rot = 2'($urandom);
      cyc = 0;
      while (!cmd_ready && cyc < 1000) begin
         @(posedge clk_sys); #1;
         cyc++;
      end
      if (op == 2'd3) begin
         checkOutput("op3_ready", {31'd0, cyc <= 1}, 32'd1);
         checkOutput("op3_busy", busyTotal - b0, 32'd0);
      end else begin
         checkOutput("latency", cyc, expLat);
         checkOutput("busy_cycles", busyTotal - b0, expLat);
         checkOutput("osd_cycles", osdTotal - o0, expLat - GAP);
      end
   endtask

   initial begin
      int n, hi;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

      repeat (3) @(posedge clk_sys);
      #1;
      checkOutput("reset_outputs", {4'd0, io_osd, io_strobe, io_din, rd_addr, busy, cmd_ready}, 32'd0);
      @(negedge clk_sys); reset_n = 1'b1;
      @(posedge clk_sys); #1;
      checkOutput("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

      applyStimulus(2'd0, 1'b0, 5'd0, 12'h0, 12'h0, 6'h0, 6'h0, 2'd0, 4);
      applyStimulus(2'd1, 1'b0, 5'd9, 12'hABC, 12'h111, 6'h3F, 6'h01, 2'd3, 4);
      applyStimulus(2'd1, 1'b1, 5'd0, 12'h123, 12'h045, 6'h20, 6'h08, 2'd1, 14);
      applyStimulus(2'd3, 1'b1, 5'd7, 12'h555, 12'h666, 6'h11, 6'h22, 2'd2, 0);
      applyStimulus(2'd2, 1'b0, 5'd3, 12'h0, 12'h0, 6'h0, 6'h0, 2'd0, 772);
      checkOutput("rd_addr_last", {24'd0, rd_addr}, 32'd255);

      // Wide-strobe instance: 3-cycle strobe, word stable from SETUP through STROBE.
      cmd_op = 2'd0; cmd_valid3 = 1'b1;
      @(posedge clk_sys); #1;
      cmd_valid3 = 1'b0;
      checkOutput("stb3_setup", {15'd0, io_strobe3, io_din3}, 32'h0000_0040);
      n = 0; hi = 0;
      while (!cmd_ready3 && n < 30) begin
         @(posedge clk_sys); #1;
         n++;
         if (io_strobe3) begin
            hi++;
            checkOutput("stb3_din", {16'd0, io_din3}, 32'h0040);
         end
      end
      checkOutput("stb3_width", hi, 32'd3);
      checkOutput("stb3_latency", n, 32'd7);

      // Reset in the middle of data word 100 of a block write.
      waitReady("ready_timeout");
      cmd_op = 2'd2; cmd_row = 5'd5; cmd_valid = 1'b1;
      @(posedge clk_sys); #1;
      cmd_valid = 1'b0;
      n = 0;
      while (!(rd_addr == 8'd100 && io_strobe) && n < 2000) begin
         @(posedge clk_sys); #1;
         n++;
      end
      checkOutput("reached_word100", {31'd0, rd_addr == 8'd100 && io_strobe}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("reset_mid_cmd", {4'd0, io_osd, io_strobe, io_din, rd_addr, busy, cmd_ready}, 32'd0);
      expQ.delete();
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys); reset_n = 1'b1;
      @(posedge clk_sys); #1;
      checkOutput("ready_after_abort", {31'd0, cmd_ready}, 32'd1);
      applyStimulus(2'd1, 1'b1, 5'd0, 12'h9A7, 12'h03C, 6'h15, 6'h2A, 2'd2, 14);

      // Back-to-back commands with cmd_valid held high; inputs churn while busy.
      cmd_op = 2'd1; cmd_info = 1'b1; infox = 12'h321; infoy = 12'h0FE;
      infow = 6'h05; infoh = 6'h06; rot = 2'd3;
      cmd_valid = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk_sys); #1;
         if (busy) begin
            cmd_op = 2'($urandom_range(0, 1)); cmd_info = 1'($urandom);
            infox = 12'($urandom); infoy = 12'($urandom); infow = 6'($urandom);
            infoh = 6'($urandom); rot = 2'($urandom);
         end
      end
      cmd_valid = 1'b0;
      @(posedge clk_sys); #1;
      waitReady("ready_timeout");
      repeat (3) @(posedge clk_sys);
      #1;
      checkOutput("sb_drain", expQ.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
